// File: rtl/panel_kbd_switches.sv
// panel_kbd_switches: turns hps_io ps2_key events into the 25 two-bit front-panel switch fields.
// Define PANEL_SWITCH_STRETCH_EN to keep momentary switches deflected for at least MIN_HOLD cycles.
module panel_kbd_switches #(
    parameter int MIN_HOLD      = 1000000,
    parameter int POWER_DEFAULT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        kbd_enable,
    output logic [49:0] switches_status,
    output logic        sw_event,
    output logic [4:0]  sw_index
);
    // Toggle slots 0-15 are switches 0-15; slot 16 is the power switch (index 24).
    localparam logic [7:0] TOG_CODES [17] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                              8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                                              8'h4D};
    localparam logic [7:0] UP_CODES [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    localparam logic [7:0] DN_CODES [8] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41};

    if (MIN_HOLD < 1) begin : g_bad_min_hold
        $error("MIN_HOLD must be at least 1");
    end

`ifdef PANEL_SWITCH_STRETCH_EN
    typedef enum logic [1:0] {M_IDLE, M_ACTIVE, M_STRETCH} mom_state_t;
    localparam int CW = $clog2(MIN_HOLD + 1);
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_d [8];
`else
    typedef enum logic [1:0] {M_IDLE, M_ACTIVE} mom_state_t;
`endif

    mom_state_t  st_q [8];
    mom_state_t  st_d [8];
    logic [7:0]  dir_q, dir_d;
    logic [16:0] on_q, on_d;
    logic [16:0] held_q, held_d;
    logic        tog_q;
    logic        key_valid, key_press;
    logic        tog_hit, mom_hit, mom_down;
    logic [4:0]  tog_slot;
    logic [2:0]  mom_slot;
    logic        key_chg, exp_chg;
    logic [4:0]  key_idx, exp_idx;

    assign key_valid = (ps2_key[10] != tog_q) && kbd_enable && !ps2_key[8];
    assign key_press = ps2_key[9];

    always_comb begin
        tog_hit  = 1'b0;
        tog_slot = '0;
        mom_hit  = 1'b0;
        mom_slot = '0;
        mom_down = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (ps2_key[7:0] == TOG_CODES[i]) begin
                tog_hit  = 1'b1;
                tog_slot = 5'(i);
            end
        end
        for (int m = 0; m < 8; m++) begin
            if (ps2_key[7:0] == UP_CODES[m]) begin
                mom_hit  = 1'b1;
                mom_slot = 3'(m);
                mom_down = 1'b0;
            end
            if (ps2_key[7:0] == DN_CODES[m]) begin
                mom_hit  = 1'b1;
                mom_slot = 3'(m);
                mom_down = 1'b1;
            end
        end
    end

    always_comb begin
        on_d    = on_q;
        held_d  = held_q;
        st_d    = st_q;
        dir_d   = dir_q;
        key_chg = 1'b0;
        key_idx = '0;
        exp_chg = 1'b0;
        exp_idx = '0;
`ifdef PANEL_SWITCH_STRETCH_EN
        for (int m = 0; m < 8; m++)
            cnt_d[m] = (st_q[m] != M_IDLE && cnt_q[m] != '0) ? cnt_q[m] - CW'(1) : cnt_q[m];
`endif
        if (key_valid && tog_hit) begin
            if (!key_press) begin
                held_d[tog_slot] = 1'b0;
            end else if (!held_q[tog_slot]) begin
                on_d[tog_slot]   = ~on_q[tog_slot];
                held_d[tog_slot] = 1'b1;
                key_chg          = 1'b1;
                key_idx          = (tog_slot == 5'd16) ? 5'd24 : tog_slot;
            end
        end else if (key_valid && mom_hit) begin
            key_idx = 5'd16 + 5'(mom_slot);
            if (key_press) begin
                // Last press wins; a repeat of the driving key is typematic and ignored.
                if (st_q[mom_slot] != M_ACTIVE || dir_q[mom_slot] != mom_down) begin
                    key_chg         = (st_q[mom_slot] == M_IDLE) || (dir_q[mom_slot] != mom_down);
                    st_d[mom_slot]  = M_ACTIVE;
                    dir_d[mom_slot] = mom_down;
`ifdef PANEL_SWITCH_STRETCH_EN
                    cnt_d[mom_slot] = CW'(MIN_HOLD);
`endif
                end
            end else if (st_q[mom_slot] == M_ACTIVE && dir_q[mom_slot] == mom_down) begin
`ifdef PANEL_SWITCH_STRETCH_EN
                // The counter holds the deflected cycles still owed, including the current one.
                if (cnt_q[mom_slot] > CW'(1)) begin
                    st_d[mom_slot] = M_STRETCH;
                end else begin
                    st_d[mom_slot] = M_IDLE;
                    key_chg        = 1'b1;
                end
`else
                st_d[mom_slot] = M_IDLE;
                key_chg        = 1'b1;
`endif
            end
        end
`ifdef PANEL_SWITCH_STRETCH_EN
        for (int m = 7; m >= 0; m--) begin
            if (st_q[m] == M_STRETCH && st_d[m] == M_STRETCH && cnt_q[m] <= CW'(1)) begin
                st_d[m] = M_IDLE;
                exp_chg = 1'b1;
                exp_idx = 5'(16 + m);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_q    <= 1'b0;
            on_q     <= {(POWER_DEFAULT != 0), 16'h0000};
            held_q   <= '0;
            dir_q    <= '0;
            sw_event <= 1'b0;
            sw_index <= '0;
            for (int m = 0; m < 8; m++) begin
                st_q[m]  <= M_IDLE;
`ifdef PANEL_SWITCH_STRETCH_EN
                cnt_q[m] <= '0;
`endif
            end
        end else begin
            tog_q    <= ps2_key[10];
            on_q     <= on_d;
            held_q   <= held_d;
            dir_q    <= dir_d;
            sw_event <= key_chg | exp_chg;
            sw_index <= key_chg ? key_idx : exp_idx;
            for (int m = 0; m < 8; m++) begin
                st_q[m]  <= st_d[m];
`ifdef PANEL_SWITCH_STRETCH_EN
                cnt_q[m] <= cnt_d[m];
`endif
            end
        end
    end

    always_comb begin
        switches_status = '0;
        for (int i = 0; i < 16; i++)
            switches_status[2*i +: 2] = {1'b0, on_q[i]};
        for (int m = 0; m < 8; m++)
            if (st_q[m] != M_IDLE)
                switches_status[32 + 2*m +: 2] = dir_q[m] ? 2'b10 : 2'b01;
        switches_status[49:48] = {1'b0, on_q[16]};
    end
endmodule

// File: tb/tb_panel_kbd_switches.sv
// tb_panel_kbd_switches: directed and random key traffic against a timestamp-based switch model.
// Builds with or without PANEL_SWITCH_STRETCH_EN; the model follows the same macro.
module tb_panel_kbd_switches;
    localparam int MIN_HOLD      = 20;
    localparam int POWER_DEFAULT = 1;
    localparam logic [49:0] RESET_STATUS = 50'h1_0000_0000_0000;
`ifdef PANEL_SWITCH_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        kbd_enable;
    logic [49:0] switches_status;
    logic        sw_event;
    logic [4:0]  sw_index;

    panel_kbd_switches #(.MIN_HOLD(MIN_HOLD), .POWER_DEFAULT(POWER_DEFAULT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ps2_key         (ps2_key),
        .kbd_enable      (kbd_enable),
        .switches_status (switches_status),
        .sw_event        (sw_event),
        .sw_index        (sw_index)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [54:0] exp_q[$];
    logic [54:0] mon_e;

    logic [7:0] tog_codes [17] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                   8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4D};
    logic [7:0] up_codes [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    logic [7:0] dn_codes [8] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41};

    // Model state: momentary switches remember when they were deflected, not a counter.
    int unsigned cyc = 0;
    bit          tog_prev;
    bit          t_on [17];
    bit          t_held [17];
    int          m_dir [8];
    bit          m_act [8];
    int unsigned m_t [8];
    logic [49:0] exp_status;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [49:0] pack_status();
        logic [49:0] s = '0;
        for (int i = 0; i < 16; i++) s[2*i +: 2] = t_on[i] ? 2'b01 : 2'b00;
        for (int m = 0; m < 8; m++) s[32 + 2*m +: 2] = 2'(m_dir[m]);
        s[49:48] = t_on[16] ? 2'b01 : 2'b00;
        return s;
    endfunction

    function automatic int tog_lookup(input logic [7:0] c);
        for (int i = 0; i < 17; i++) if (tog_codes[i] == c) return i;
        return -1;
    endfunction

    function automatic int mom_lookup(input logic [7:0] c, output int d);
        d = 0;
        for (int m = 0; m < 8; m++) begin
            if (up_codes[m] == c) begin d = 1; return m; end
            if (dn_codes[m] == c) begin d = 2; return m; end
        end
        return -1;
    endfunction

    function automatic void model_reset();
        tog_prev = 1'b0;
        for (int i = 0; i < 17; i++) begin t_on[i] = 1'b0; t_held[i] = 1'b0; end
        t_on[16] = (POWER_DEFAULT != 0);
        for (int m = 0; m < 8; m++) begin m_dir[m] = 0; m_act[m] = 1'b0; m_t[m] = 0; end
        exp_status = pack_status();
        exp_q.delete();
    endfunction

    function automatic void model_step();
        int t, m, d, key_idx, exp_idx;
        bit press;
        cyc++;
        key_idx = -1;
        exp_idx = -1;
        if (ps2_key[10] != tog_prev && kbd_enable && !ps2_key[8]) begin
            press = ps2_key[9];
            t = tog_lookup(ps2_key[7:0]);
            m = mom_lookup(ps2_key[7:0], d);
            if (t >= 0) begin
                if (!press) t_held[t] = 1'b0;
                else if (!t_held[t]) begin
                    t_on[t] = !t_on[t];
                    t_held[t] = 1'b1;
                    key_idx = (t == 16) ? 24 : t;
                end
            end else if (m >= 0) begin
                if (press) begin
                    if (!(m_act[m] && m_dir[m] == d)) begin
                        if (m_dir[m] != d) key_idx = 16 + m;
                        m_dir[m] = d;
                        m_act[m] = 1'b1;
                        m_t[m] = cyc;
                    end
                end else if (m_act[m] && m_dir[m] == d) begin
                    m_act[m] = 1'b0;
                    if (!STRETCH || cyc >= m_t[m] + MIN_HOLD) begin
                        m_dir[m] = 0;
                        key_idx = 16 + m;
                    end
                end
            end
        end
        tog_prev = ps2_key[10];
        for (int k = 7; k >= 0; k--) begin
            if (m_dir[k] != 0 && !m_act[k] && cyc >= m_t[k] + MIN_HOLD) begin
                m_dir[k] = 0;
                exp_idx = 16 + k;
            end
        end
        exp_status = pack_status();
        if (key_idx >= 0 || exp_idx >= 0)
            exp_q.push_back({5'(key_idx >= 0 ? key_idx : exp_idx), exp_status});
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("status", switches_status, exp_status);
            if (exp_q.size() == 0) begin
                check("sw_event_idle", sw_event, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sw_event_pulse", sw_event, 1'b1);
                check("sw_index", sw_index, mon_e[54:50]);
                check("event_status", switches_status, mon_e[49:0]);
            end
        end
    end

    task automatic send(input logic [7:0] code, input bit press, input bit ext);
        @(negedge clk);
        ps2_key = {~ps2_key[10], press, ext, code};
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] pick_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45) return $urandom_range(0, 1) ? up_codes[$urandom_range(0, 7)] : dn_codes[$urandom_range(0, 7)];
        if (r < 90) return tog_codes[$urandom_range(0, 16)];
        return (r < 95) ? 8'h5A : 8'h76;
    endfunction

    initial begin
        reset_n    = 1'b0;
        ps2_key    = '0;
        kbd_enable = 1'b1;
        model_reset();
        idle(3);
        check("reset_status", switches_status, RESET_STATUS);
        check("reset_sw_event", sw_event, 1'b0);
        reset_n = 1'b1;
        idle(2);

        // toggle switch 0: press, typematic repeat, release, press, release
        send(8'h16, 1, 0); idle(1); send(8'h16, 1, 0); idle(1);
        send(8'h16, 0, 0); send(8'h16, 1, 0); idle(2); send(8'h16, 0, 0); idle(2);

        // momentary switch 16: short press, held deflected for the minimum time
        send(8'h1C, 1, 0); idle(2); send(8'h1C, 0, 0); idle(25);

        // momentary switch 17: last press wins, non-driving release ignored
        send(8'h1B, 1, 0); idle(2); send(8'h22, 1, 0); idle(2);
        send(8'h1B, 0, 0); idle(2); send(8'h22, 0, 0); idle(25);

        // disabled keyboard and extended scancode are dropped
        kbd_enable = 1'b0; send(8'h16, 1, 0); idle(2);
        kbd_enable = 1'b1; send(8'h16, 1, 1); idle(3);

        // key-driven toggle lands on the same cycle as switch 16's expiry
        send(8'h1C, 1, 0); send(8'h1C, 0, 0); idle(18);
        send(8'h16, 1, 0); idle(2); send(8'h16, 0, 0); idle(3);

        // power switch
        send(8'h4D, 1, 0); send(8'h4D, 0, 0); send(8'h4D, 1, 0); send(8'h4D, 0, 0); idle(2);

        // reset while switch 20 is stretching and switch 5 is on
        send(8'h34, 1, 0); send(8'h34, 0, 0); send(8'h36, 1, 0); idle(3);
        #2 reset_n = 1'b0;
        ps2_key = '0;
        #1 check("async_reset_status", switches_status, RESET_STATUS);
        check("async_reset_sw_event", sw_event, 1'b0);
        idle(2);
        reset_n = 1'b1;
        idle(3);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            kbd_enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) == 0)
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), pick_code()};
            else
                ps2_key = {ps2_key[10], 10'($urandom)};
        end

        kbd_enable = 1'b1;
        idle(MIN_HOLD + 5);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
